// File: rtl/edge_gen_pkg.sv
// Shared types and default widths for the edge generator.
// Optional edge-flag outputs are enabled with EDGE_GEN_EDGE_FLAGS_EN.
package edge_gen_pkg;

   localparam int CNT_W_DEF = 8;
   localparam int NP_W_DEF  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

endpackage

// File: rtl/edge_gen_counter.sv
// Loadable down-counter with a zero flag; saturates at zero instead of wrapping.
module edge_gen_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering in simulation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/edge_generator.sv
// Pulse-train generator: num_pulses high phases separated by low phases.
// Define EDGE_GEN_EDGE_FLAGS_EN to add the registered pulse_out_p/pulse_out_n edge flags.
module edge_generator
   import edge_gen_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int NP_W  = NP_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] high_len,
   input  logic [CNT_W-1:0] low_len,
   input  logic [NP_W-1:0]  num_pulses,
   output logic             sig_out,
   output logic             busy,
   output logic             done
`ifdef EDGE_GEN_EDGE_FLAGS_EN
   ,
   output logic             pulse_out_p,
   output logic             pulse_out_n
`endif
);

   // Counters hold (length - 1) so a phase ends on the cycle its counter reads zero;
   // a length of 0 therefore behaves exactly like a length of 1.
   function automatic logic [CNT_W-1:0] phase_load(input logic [CNT_W-1:0] len);
      return (len == '0) ? '0 : len - CNT_W'(1);
   endfunction

   state_t           r_state;
   logic             r_sig_out;
   logic             r_busy;
   logic             r_done;
   logic [CNT_W-1:0] r_high_len;
   logic [CNT_W-1:0] r_low_len;
   logic [NP_W-1:0]  r_pulses;

   logic             w_in_idle;
   logic             w_in_high;
   logic             w_in_low;
   logic             w_accept;
   logic             w_last;
   logic             w_hi_zero;
   logic             w_lo_zero;
   logic             w_hi_load;
   logic             w_lo_load;
   logic             w_fall;
   logic [CNT_W-1:0] w_hi_src;
   logic [CNT_W-1:0] w_hi_load_val;
   logic [CNT_W-1:0] w_lo_load_val;

   assign w_in_idle = (r_state == IDLE);
   assign w_in_high = (r_state == HIGH);
   assign w_in_low  = (r_state == LOW);

   // abort outranks start, and a zero-length train never leaves IDLE.
   assign w_accept  = start & ~abort & (num_pulses != '0);
   assign w_last    = (r_pulses == NP_W'(1));

   // On the accepting edge the lengths are not latched yet, so use the live inputs.
   assign w_hi_src      = w_in_idle ? high_len : r_high_len;
   assign w_hi_load_val = phase_load(w_hi_src);
   assign w_lo_load_val = phase_load(r_low_len);

   assign w_hi_load = (w_in_idle & w_accept) | (w_in_low & ~abort & w_lo_zero);
   assign w_lo_load = w_in_high & ~abort & w_hi_zero & ~w_last;
   assign w_fall    = w_in_high & (abort | w_hi_zero);

   edge_gen_counter #(.W(CNT_W)) u_high_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (abort),
      .i_load     (w_hi_load),
      .i_load_val (w_hi_load_val),
      .i_dec      (w_in_high),
      .o_zero     (w_hi_zero)
   );

   edge_gen_counter #(.W(CNT_W)) u_low_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (abort),
      .i_load     (w_lo_load),
      .i_load_val (w_lo_load_val),
      .i_dec      (w_in_low),
      .o_zero     (w_lo_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_sig_out  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_high_len <= '0;
         r_low_len  <= '0;
         r_pulses   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start && !abort) begin
                  if (num_pulses != '0) begin
                     r_state    <= HIGH;
                     r_sig_out  <= 1'b1;
                     r_busy     <= 1'b1;
                     r_high_len <= high_len;
                     r_low_len  <= low_len;
                     r_pulses   <= num_pulses;
                  end else begin
                     r_done <= 1'b1;
                  end
               end
            end
            HIGH: begin
               if (abort) begin
                  r_state   <= IDLE;
                  r_sig_out <= 1'b0;
                  r_busy    <= 1'b0;
                  r_pulses  <= '0;
               end else if (w_hi_zero) begin
                  r_sig_out <= 1'b0;
                  if (w_last) begin
                     r_state  <= IDLE;
                     r_busy   <= 1'b0;
                     r_done   <= 1'b1;
                     r_pulses <= '0;
                  end else begin
                     r_state  <= LOW;
                     r_pulses <= r_pulses - NP_W'(1);
                  end
               end
            end
            LOW: begin
               if (abort) begin
                  r_state  <= IDLE;
                  r_busy   <= 1'b0;
                  r_pulses <= '0;
               end else if (w_lo_zero) begin
                  r_state   <= HIGH;
                  r_sig_out <= 1'b1;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_sig_out <= 1'b0;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end

   assign sig_out = r_sig_out;
   assign busy    = r_busy;
   assign done    = r_done;

`ifdef EDGE_GEN_EDGE_FLAGS_EN
   logic r_pulse_p;
   logic r_pulse_n;

   // Every rise coincides with a high-counter load; reset clears sig_out without a flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pulse_p <= 1'b0;
         r_pulse_n <= 1'b0;
      end else begin
         r_pulse_p <= w_hi_load;
         r_pulse_n <= w_fall;
      end
   end

   assign pulse_out_p = r_pulse_p;
   assign pulse_out_n = r_pulse_n;
`endif

endmodule

// File: tb/tb_edge_generator.sv
// Scoreboard bench for edge_generator: expected per-cycle outputs are queued at stimulus time.
module tb_edge_generator;
   import edge_gen_pkg::*;

   localparam int CNT_W = CNT_W_DEF;
   localparam int NP_W  = NP_W_DEF;

   typedef struct packed {
      logic sig;
      logic busy;
      logic done;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] high_len;
   logic [CNT_W-1:0] low_len;
   logic [NP_W-1:0]  num_pulses;
   logic             sig_out;
   logic             busy;
   logic             done;
`ifdef EDGE_GEN_EDGE_FLAGS_EN
   logic             pulse_out_p;
   logic             pulse_out_n;
   logic             prev_sig = 1'b0;
`endif

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   edge_generator #(.CNT_W(CNT_W), .NP_W(NP_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .high_len   (high_len),
      .low_len    (low_len),
      .num_pulses (num_pulses),
      .sig_out    (sig_out),
      .busy       (busy),
`ifdef EDGE_GEN_EDGE_FLAGS_EN
      .done       (done),
      .pulse_out_p(pulse_out_p),
      .pulse_out_n(pulse_out_n)
`else
      .done       (done)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic push(input logic s, input logic b, input logic d);
      exp_t e;
      e.sig  = s;
      e.busy = b;
      e.done = d;
      exp_q.push_back(e);
   endtask

   // One clock: one-cycle request inputs drop after the edge, outputs compared mid-cycle.
   task automatic step(input string name, input int idx);
      exp_t e;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("%s.sig@%0d", name, idx), sig_out, e.sig);
      check($sformatf("%s.busy@%0d", name, idx), busy, e.busy);
      check($sformatf("%s.done@%0d", name, idx), done, e.done);
`ifdef EDGE_GEN_EDGE_FLAGS_EN
      check($sformatf("%s.pulse_p@%0d", name, idx), pulse_out_p, e.sig & ~prev_sig);
      check($sformatf("%s.pulse_n@%0d", name, idx), pulse_out_n, ~e.sig & prev_sig);
      prev_sig = e.sig;
`endif
   endtask

   task automatic drain(input string name, input int abort_at, input int restart_at);
      int i = 0;
      while (exp_q.size() > 0 && i < 2000) begin
         i++;
         step(name, i);
         if (i == abort_at) abort = 1'b1;
         if (i == restart_at) begin
            start      = 1'b1;
            high_len   = CNT_W'(1);
            low_len    = CNT_W'(7);
            num_pulses = NP_W'(9);
         end
      end
      check({name, ".drained"}, exp_q.size(), 0);
   endtask

   // Expected waveform built from the pulse-train definition, truncated by abort.
   task automatic run_train(input string name, input int h, input int l, input int n,
                            input int abort_at, input int restart_at);
      exp_t tq[$];
      exp_t e;
      int   he;
      int   le;
      high_len   = CNT_W'(h);
      low_len    = CNT_W'(l);
      num_pulses = NP_W'(n);
      start      = 1'b1;
      he = (h == 0) ? 1 : h;
      le = (l == 0) ? 1 : l;
      for (int p = 1; p <= n; p++) begin
         for (int k = 0; k < he; k++) begin
            e = '{sig: 1'b1, busy: 1'b1, done: 1'b0};
            tq.push_back(e);
         end
         if (p < n) begin
            for (int k = 0; k < le; k++) begin
               e = '{sig: 1'b0, busy: 1'b1, done: 1'b0};
               tq.push_back(e);
            end
         end
      end
      e = '{sig: 1'b0, busy: 1'b0, done: 1'b1};
      tq.push_back(e);
      if (abort_at > 0) begin
         for (int k = 0; k < abort_at; k++) exp_q.push_back(tq[k]);
         push(1'b0, 1'b0, 1'b0);
      end else begin
         foreach (tq[k]) exp_q.push_back(tq[k]);
      end
      push(1'b0, 1'b0, 1'b0);
      push(1'b0, 1'b0, 1'b0);
      drain(name, abort_at, restart_at);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before the run completed");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      abort      = 1'b0;
      high_len   = '0;
      low_len    = '0;
      num_pulses = '0;

      #12;
      check("reset.sig", sig_out, 1'b0);
      check("reset.busy", busy, 1'b0);
      check("reset.done", done, 1'b0);
      #8;
      rst = 1'b0;

      // Start on the first edge after reset release.
      run_train("basic_3_2_2", 3, 2, 2, 0, 0);
      run_train("zero_lens", 0, 0, 3, 0, 0);
      run_train("zero_pulses", 4, 4, 0, 0, 0);
      run_train("abort_low", 5, 5, 4, 7, 0);
      run_train("abort_high", 3, 2, 2, 2, 0);
      run_train("restart_ignored", 4, 3, 2, 0, 1);
      run_train("max_pulses", 1, 1, 15, 0, 0);
      run_train("max_high", 255, 9, 1, 0, 0);

      start = 1'b1;
      abort = 1'b1;
      high_len   = CNT_W'(2);
      num_pulses = NP_W'(2);
      push(1'b0, 1'b0, 1'b0);
      push(1'b0, 1'b0, 1'b0);
      drain("abort_start_idle", 0, 0);

      // Reset in the middle of a HIGH phase.
      high_len   = CNT_W'(6);
      low_len    = CNT_W'(2);
      num_pulses = NP_W'(3);
      start      = 1'b1;
      push(1'b1, 1'b1, 1'b0);
      push(1'b1, 1'b1, 1'b0);
      drain("mid_high", 0, 0);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async.sig", sig_out, 1'b0);
      check("rst_async.busy", busy, 1'b0);
      check("rst_async.done", done, 1'b0);
`ifdef EDGE_GEN_EDGE_FLAGS_EN
      check("rst_async.pulse_p", pulse_out_p, 1'b0);
      check("rst_async.pulse_n", pulse_out_n, 1'b0);
      prev_sig = 1'b0;
`endif
      @(negedge clk);
      rst = 1'b0;
      push(1'b0, 1'b0, 1'b0);
      push(1'b0, 1'b0, 1'b0);
      push(1'b0, 1'b0, 1'b0);
      drain("after_rst", 0, 0);

      run_train("post_rst_train", 2, 1, 2, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
